// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO UART transmitter, FIFO-fed 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined)
module uart_tx_mmio #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic        io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        TXD,
    output logic        tx_busy
);
    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      data_q;
    logic            txd_q;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            ovf_q;
    logic [31:0]     rdata_q;
    logic            empty, full, cnt_last, pop, wr_data, push, drop, unused_ok;
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cnt_last  = cnt_q == CW'(DIV - 1);
    assign pop       = !empty && (state_q == IDLE || (state_q == STOP && cnt_last));
    assign wr_data   = io_wr && !io_addr;
    assign push      = wr_data && (!full || pop);
    assign drop      = wr_data && full && !pop;
    assign tx_busy   = !empty || state_q != IDLE;
    assign TXD       = txd_q;
    assign io_rdata  = rdata_q;
    assign unused_ok = &{1'b0, io_wdata[31:8]};
    // FIFO pointers, storage and sticky overflow; an overflowing push beats a same-cycle clear
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= io_wdata[7:0];
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q <= drop || (ovf_q && !(io_wr && io_addr && io_wdata[3]));
        end
    end
    // Frame serialiser: each non-idle state lasts DIV cycles, TXD registered alongside the state
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
        end else begin
            cnt_q <= (state_q == IDLE || cnt_last) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    data_q  <= mem_q[rd_ptr_q[AW-1:0]];
                    txd_q   <= 1'b0;
                end
                START: if (cnt_last) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    txd_q   <= data_q[0];
                end
                DATA: if (cnt_last) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_q <= PARITY;
                        txd_q   <= ^data_q;
`else
                        state_q <= STOP;
                        txd_q   <= 1'b1;
`endif
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        txd_q <= data_q[bit_q + 3'd1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (cnt_last) begin
                    state_q <= STOP;
                    txd_q   <= 1'b1;
                end
`endif
                STOP: if (cnt_last) begin
                    state_q <= pop ? START : IDLE;
                    txd_q   <= !pop;
                    if (pop) data_q <= mem_q[rd_ptr_q[AW-1:0]];
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end
    // Registered read port; holds its value between reads
    always_ff @(posedge CLK) begin
        if (!resetn) rdata_q <= '0;
        else if (io_rd) rdata_q <= io_addr ? {28'b0, ovf_q, empty, full, tx_busy} : '0;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized self-checking bench for uart_tx_mmio against a line-level reference model
module tb_uart_tx_mmio;
    localparam int DIV = 4;
    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_addr = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        TXD, tx_busy;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo_m[$];
    logic        line_m[$];
    logic        ovf_m = 1'b0;
    logic [31:0] rdata_m = '0;

    uart_tx_mmio #(.CLK_FREQ_HZ(40), .BAUD(10), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .resetn(resetn), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .TXD(TXD), .tx_busy(tx_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_m();
        return {28'b0, ovf_m, fifo_m.size() == 0, fifo_m.size() == 4, fifo_m.size() > 0 || line_m.size() > 0};
    endfunction

    function automatic void add_frame(input logic [7:0] b);
        repeat (DIV) line_m.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (DIV) line_m.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        repeat (DIV) line_m.push_back(^b);
`endif
        repeat (DIV) line_m.push_back(1'b1);
    endfunction

    task automatic step(input logic rn, input logic wr, input logic rd, input logic addr, input logic [31:0] wd);
        logic was_full, pop, drop;
        @(negedge CLK);
        resetn = rn; io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wd;
        if (!rn) begin
            fifo_m.delete();
            line_m.delete();
            ovf_m = 1'b0;
            rdata_m = '0;
        end else begin
            if (rd) rdata_m = addr ? status_m() : 32'h0;
            if (line_m.size() > 0) void'(line_m.pop_front());
            was_full = fifo_m.size() == 4;
            pop = line_m.size() == 0 && fifo_m.size() > 0;
            drop = wr && !addr && was_full && !pop;
            if (pop) add_frame(fifo_m.pop_front());
            if (wr && !addr && !drop) fifo_m.push_back(wd[7:0]);
            ovf_m = drop || (ovf_m && !(wr && addr && wd[3]));
        end
        @(posedge CLK);
        #1;
        chk("TXD", {31'b0, TXD}, {31'b0, line_m.size() > 0 ? line_m[0] : 1'b1});
        chk("busy", {31'b0, tx_busy}, {31'b0, fifo_m.size() > 0 || line_m.size() > 0});
        chk("rdata", io_rdata, rdata_m);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr_data(input logic [7:0] b);
        step(1'b1, 1'b1, 1'b0, 1'b0, {24'h0, b});
    endtask

    task automatic rd_stat();
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(20);
        rd_stat();
        chk("status_reset", io_rdata, 32'h4);
        wr_data(8'h55);
        idle(45);
        for (int i = 1; i <= 6; i++) wr_data(8'(i));
        rd_stat();
        chk("status_ovf", io_rdata, 32'hB);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
        rd_stat();
        chk("status_clr", io_rdata, 32'h3);
        idle(5 * 10 * DIV + 20);
        wr_data(8'hA5);
        wr_data(8'h3C);
        wr_data(8'h0F);
        idle(15);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("txd_after_rst", {31'b0, TXD}, 32'h1);
        rd_stat();
        chk("status_after_rst", io_rdata, 32'h4);
        idle(60);
        wr_data(8'h07);
        idle(50);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("data_read", io_rdata, 32'h0);
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 299);
            if (r == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            else step(1'b1, r < 60, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom);
        end
        idle(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
